// File: rtl/fpu_wb_merge.sv
// Merges late FPU writebacks with the main-pipe writeback onto the single register-file write port.
// Queue forwarding to decode is built only when WB_MERGE_FWD_EN is defined.
module fpu_wb_merge #(
    parameter int PC_LEN = 17,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     RegWrite_pipe,
    input  logic [5:0]               RdW_pipe,
    input  logic [31:0]              ResultW_pipe,
    input  logic [PC_LEN-3:0]        PCW_pipe,
    input  logic                     RegWrite_fpu,
    input  logic [5:0]               RdW_fpu,
    input  logic [31:0]              ResultW_fpu,
    input  logic [PC_LEN-3:0]        PCW_fpu,
    input  logic [5:0]               Rs1D,
    input  logic [5:0]               Rs2D,
    output logic                     RegWriteRF,
    output logic [5:0]               RdRF,
    output logic [31:0]              ResultRF,
    output logic [PC_LEN-3:0]        PCRF,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [31:0]              fwd_data1,
    output logic [31:0]              fwd_data2,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("fpu_wb_merge: DEPTH must be a power of two, at least 2");
    end

    logic [5:0]        q_rd   [DEPTH];
    logic [31:0]       q_data [DEPTH];
    logic [PC_LEN-3:0] q_pc   [DEPTH];
    logic [DEPTH-1:0]  q_live;
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;

    logic              pipe_acc;
    logic              fpu_acc;
    logic              push;
    logic              pop;
    logic              push_ok;
    logic              wr_en;
    logic [5:0]        wr_rd;
    logic [31:0]       wr_data;
    logic [PC_LEN-3:0] wr_pc;

    assign pipe_acc = RegWrite_pipe && (RdW_pipe != 6'd0);
    assign fpu_acc  = RegWrite_fpu && (RdW_fpu != 6'd0);

    // Pipe owns the port; otherwise the queue drains before any direct FPU write.
    always_comb begin
        wr_en   = 1'b0;
        wr_rd   = '0;
        wr_data = '0;
        wr_pc   = '0;
        push    = 1'b0;
        pop     = 1'b0;
        if (pipe_acc) begin
            wr_en   = 1'b1;
            wr_rd   = RdW_pipe;
            wr_data = ResultW_pipe;
            wr_pc   = PCW_pipe;
            push    = fpu_acc && (RdW_fpu != RdW_pipe);
        end else if (count != '0) begin
            pop  = 1'b1;
            push = fpu_acc;
            if (q_live[head]) begin
                wr_en   = 1'b1;
                wr_rd   = q_rd[head];
                wr_data = q_data[head];
                wr_pc   = q_pc[head];
            end
        end else if (fpu_acc) begin
            wr_en   = 1'b1;
            wr_rd   = RdW_fpu;
            wr_data = ResultW_fpu;
            wr_pc   = PCW_fpu;
        end
    end

    assign push_ok = push && ((count != CW'(DEPTH)) || pop);
    assign full    = (count >= CW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            RegWriteRF <= 1'b0;
            RdRF       <= '0;
            ResultRF   <= '0;
            PCRF       <= '0;
        end else begin
            RegWriteRF <= wr_en;
            RdRF       <= wr_rd;
            ResultRF   <= wr_data;
            PCRF       <= wr_pc;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q_live   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_acc && q_live[i] && (q_rd[i] == RdW_pipe)) begin
                    q_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                q_live[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            // Ordered after the pop so a full queue popping and pushing the same slot keeps the new entry.
            if (push_ok) begin
                q_live[tail] <= 1'b1;
                tail         <= tail + 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_rd[tail]   <= RdW_fpu;
            q_data[tail] <= ResultW_fpu;
            q_pc[tail]   <= PCW_fpu;
        end
    end

`ifdef WB_MERGE_FWD_EN
    logic [AW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + AW'(i);
            if (q_live[fwd_idx] && (Rs1D != 6'd0) && (q_rd[fwd_idx] == Rs1D)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = q_data[fwd_idx];
            end
            if (q_live[fwd_idx] && (Rs2D != 6'd0) && (q_rd[fwd_idx] == Rs2D)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = q_data[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{Rs1D, Rs2D};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_fpu_wb_merge.sv
// Self-checking bench for fpu_wb_merge: expected RF writes queued per driven cycle, popped after each edge.
module tb_fpu_wb_merge;
    localparam int PCW = 15;
`ifdef WB_MERGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic           pv;
        logic [5:0]     prd;
        logic [31:0]    pd;
        logic [PCW-1:0] ppc;
        logic           fv;
        logic [5:0]     frd;
        logic [31:0]    fd;
        logic [PCW-1:0] fpc;
    } stim_t;

    logic           clk = 1'b0;
    logic           rstN = 1'b0;
    logic           RegWrite_pipe = 1'b0, RegWrite_fpu = 1'b0;
    logic [5:0]     RdW_pipe = '0, RdW_fpu = '0, Rs1D = '0, Rs2D = '0;
    logic [31:0]    ResultW_pipe = '0, ResultW_fpu = '0;
    logic [PCW-1:0] PCW_pipe = '0, PCW_fpu = '0;
    logic           RegWriteRF, fwd_hit1, fwd_hit2, full, overflow;
    logic [5:0]     RdRF;
    logic [31:0]    ResultRF, fwd_data1, fwd_data2;
    logic [PCW-1:0] PCRF;
    logic [2:0]     count;

    int n_checks = 0;
    int n_errors = 0;
    logic [58:0] sb[$];
    logic [58:0] exp_v;
    wire  [58:0] obs = {RegWriteRF, RdRF, ResultRF, PCRF, count, full, overflow};

    fpu_wb_merge #(.PC_LEN(17), .DEPTH(4)) dut (
        .clk(clk), .rstN(rstN),
        .RegWrite_pipe(RegWrite_pipe), .RdW_pipe(RdW_pipe), .ResultW_pipe(ResultW_pipe), .PCW_pipe(PCW_pipe),
        .RegWrite_fpu(RegWrite_fpu), .RdW_fpu(RdW_fpu), .ResultW_fpu(ResultW_fpu), .PCW_fpu(PCW_fpu),
        .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteRF(RegWriteRF), .RdRF(RdRF), .ResultRF(ResultRF), .PCRF(PCRF),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .full(full), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [58:0] mk(input logic en, input logic [5:0] rd, input logic [31:0] d,
                                       input logic [PCW-1:0] pc, input logic [2:0] c, input logic f,
                                       input logic o);
        return {en, rd, d, pc, c, f, o};
    endfunction

    function automatic stim_t st(input logic pv, input logic [5:0] prd, input logic [31:0] pd,
                                 input logic [PCW-1:0] ppc, input logic fv, input logic [5:0] frd,
                                 input logic [31:0] fd, input logic [PCW-1:0] fpc);
        stim_t s;
        s.pv = pv; s.prd = prd; s.pd = pd; s.ppc = ppc;
        s.fv = fv; s.frd = frd; s.fd = fd; s.fpc = fpc;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        RegWrite_pipe = s.pv; RdW_pipe = s.prd; ResultW_pipe = s.pd; PCW_pipe = s.ppc;
        RegWrite_fpu  = s.fv; RdW_fpu  = s.frd; ResultW_fpu  = s.fd; PCW_fpu  = s.fpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    stim_t idle_s;

    task automatic test_reset();
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got %h exp 0", obs);
        end
        n_checks++;
        if ({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2} !== '0) begin
            n_errors++; $display("FAIL reset_fwd: got %b %b %h %h exp 0", fwd_hit1, fwd_hit2, fwd_data1, fwd_data2);
        end
    endtask

    task automatic test_fpu_direct();
        stim_t s[$];
        s.push_back(st(0, 0, 0, 0, 1, 6'h21, 32'h3F80_0000, 15'h100)); sb.push_back(mk(1, 6'h21, 32'h3F80_0000, 15'h100, 0, 0, 0));
        s.push_back(idle_s);                                           sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (s[k]) begin
            apply(s[k]); step(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL fpu_direct[%0d]: got %h exp %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_x0();
        stim_t s[$];
        s.push_back(st(1, 6'd0, 32'h55, 15'h1, 1, 6'h26, 32'h66, 15'h2)); sb.push_back(mk(1, 6'h26, 32'h66, 15'h2, 0, 0, 0));
        s.push_back(st(0, 0, 0, 0, 1, 6'd0, 32'h77, 15'h3));             sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 6'd0, 32'h88, 15'h4, 0, 0, 0, 0));             sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (s[k]) begin
            apply(s[k]); step(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL x0[%0d]: got %h exp %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_collide();
        stim_t s[$];
        s.push_back(st(1, 6'd5, 32'd7, 15'h10, 1, 6'h22, 32'd9, 15'h11)); sb.push_back(mk(1, 6'd5, 32'd7, 15'h10, 1, 0, 0));
        s.push_back(idle_s);                                              sb.push_back(mk(1, 6'h22, 32'd9, 15'h11, 0, 0, 0));
        s.push_back(idle_s);                                              sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (s[k]) begin
            apply(s[k]); step(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL collide[%0d]: got %h exp %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_squash();
        stim_t s[$];
        s.push_back(st(1, 6'd1, 32'h11, 15'h1, 1, 6'h23, 32'hAA, 15'h2)); sb.push_back(mk(1, 6'd1, 32'h11, 15'h1, 1, 0, 0));
        s.push_back(st(1, 6'h23, 32'hBB, 15'h3, 0, 0, 0, 0));             sb.push_back(mk(1, 6'h23, 32'hBB, 15'h3, 1, 0, 0));
        s.push_back(idle_s);                                              sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        s.push_back(idle_s);                                              sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (s[k]) begin
            apply(s[k]); step(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL squash[%0d]: got %h exp %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_same_rd();
        stim_t s[$];
        s.push_back(st(1, 6'h24, 32'h5, 15'h4, 1, 6'h24, 32'h6, 15'h5)); sb.push_back(mk(1, 6'h24, 32'h5, 15'h4, 0, 0, 0));
        s.push_back(idle_s);                                             sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (s[k]) begin
            apply(s[k]); step(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL same_rd[%0d]: got %h exp %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        s.push_back(st(0, 0, 0, 0, 1, 6'h2A, 32'd1, 15'h21));           sb.push_back(mk(1, 6'h2A, 32'd1, 15'h21, 0, 0, 0));
        s.push_back(st(0, 0, 0, 0, 1, 6'h2B, 32'd2, 15'h22));           sb.push_back(mk(1, 6'h2B, 32'd2, 15'h22, 0, 0, 0));
        s.push_back(st(1, 6'd7, 32'd3, 15'h23, 1, 6'h2C, 32'd4, 15'h24)); sb.push_back(mk(1, 6'd7, 32'd3, 15'h23, 1, 0, 0));
        s.push_back(st(0, 0, 0, 0, 1, 6'h2D, 32'd5, 15'h25));           sb.push_back(mk(1, 6'h2C, 32'd4, 15'h24, 1, 0, 0));
        s.push_back(idle_s);                                            sb.push_back(mk(1, 6'h2D, 32'd5, 15'h25, 0, 0, 0));
        s.push_back(idle_s);                                            sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (s[k]) begin
            apply(s[k]); step(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL back_to_back[%0d]: got %h exp %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_fwd();
        stim_t s[$];
        logic [65:0] fexp;
        s.push_back(st(1, 6'd1, 32'd1, 15'h31, 1, 6'h25, 32'hA, 15'h32)); sb.push_back(mk(1, 6'd1, 32'd1, 15'h31, 1, 0, 0));
        s.push_back(st(1, 6'd2, 32'd2, 15'h33, 1, 6'h25, 32'hB, 15'h34)); sb.push_back(mk(1, 6'd2, 32'd2, 15'h33, 2, 0, 0));
        s.push_back(st(1, 6'd3, 32'd3, 15'h35, 0, 0, 0, 0));             sb.push_back(mk(1, 6'd3, 32'd3, 15'h35, 2, 0, 0));
        s.push_back(st(1, 6'h25, 32'hC, 15'h36, 0, 0, 0, 0));            sb.push_back(mk(1, 6'h25, 32'hC, 15'h36, 2, 0, 0));
        s.push_back(idle_s);                                             sb.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        s.push_back(idle_s);                                             sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (s[k]) begin
            apply(s[k]); step(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL fwd_wb[%0d]: got %h exp %h", k, obs, exp_v); end
            if (k == 1) begin
                Rs1D = 6'h25; Rs2D = 6'd0; #1;
                fexp = {FWD, 1'b0, (FWD ? 32'hB : 32'h0), 32'h0};
                n_checks++;
                if ({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2} !== fexp) begin
                    n_errors++; $display("FAIL fwd_youngest: got %b %b %h %h exp %h", fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, fexp);
                end
                Rs1D = 6'h01; Rs2D = 6'h25; #1;
                fexp = {1'b0, FWD, 32'h0, (FWD ? 32'hB : 32'h0)};
                n_checks++;
                if ({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2} !== fexp) begin
                    n_errors++; $display("FAIL fwd_port2: got %b %b %h %h exp %h", fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, fexp);
                end
                Rs1D = 6'h25; Rs2D = 6'd0;
            end
            if (k == 3) begin
                n_checks++;
                if ({fwd_hit1, fwd_data1} !== 33'h0) begin
                    n_errors++; $display("FAIL fwd_squashed: got %b %h exp 0 0", fwd_hit1, fwd_data1);
                end
            end
        end
        Rs1D = 6'd0; Rs2D = 6'd0;
    endtask

    task automatic test_overflow_reset();
        for (int i = 0; i < 5; i++) begin
            apply(st(1, 6'(i + 1), 32'h100 + 32'(i), 15'(i), 1, 6'h30 + 6'(i), 32'h200 + 32'(i), 15'h40 + 15'(i)));
            sb.push_back(mk(1, 6'(i + 1), 32'h100 + 32'(i), 15'(i), (i < 4) ? 3'(i + 1) : 3'd4, i >= 2, i == 4));
            step(); exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL fill[%0d]: got %h exp %h", i, obs, exp_v); end
        end
        apply(idle_s); sb.push_back(mk(1, 6'h30, 32'h200, 15'h40, 3, 1, 1));
        step(); exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL drain[0]: got %h exp %h", obs, exp_v); end
        sb.push_back(mk(1, 6'h31, 32'h201, 15'h41, 2, 0, 1));
        step(); exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL drain[1]: got %h exp %h", obs, exp_v); end
        apply(st(1, 6'd9, 32'h99, 15'h9, 1, 6'h3A, 32'h9A, 15'h9));
        #2 rstN = 1'b0;
        #1;
        n_checks++;
        if (obs !== '0) begin n_errors++; $display("FAIL async_reset: got %h exp 0", obs); end
        apply(idle_s);
        @(posedge clk); #1; rstN = 1'b1;
        step(); n_checks++;
        if (obs !== '0) begin n_errors++; $display("FAIL after_reset: got %h exp 0", obs); end
    endtask

    initial begin
        idle_s = st(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        test_reset();
        test_fpu_direct();
        test_x0();
        test_collide();
        test_squash();
        test_same_rd();
        test_back_to_back();
        test_fwd();
        test_overflow_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fpu_wb_merge.md
Name: fpu_wb_merge

Overview:
- Receiving end of the FPU late-writeback interface (RegWrite_fpu/RdW_fpu/ResultW_fpu/PCW_fpu).
- Merges FPU writebacks with the main-pipeline writeback onto the single register-file write port.
- Main pipe always wins the port. Colliding FPU results are queued in a small in-order FIFO and drained on idle cycles. Queued entries made stale by newer pipe writes are squashed.
- Exports queue-full backpressure and optional operand forwarding from the queue.

Parameters:
- PC_LEN, 17, PC width; PC fields are PC_LEN-2 bits wide, i.e. [PC_LEN-3:0].
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rstN  in  1  asynchronous active-low reset.
- RegWrite_pipe  in  1  main-pipe writeback valid.
- RdW_pipe  in  6  main-pipe destination; bit5 = float file.
- ResultW_pipe  in  32  main-pipe data.
- PCW_pipe  in  PC_LEN-2  main-pipe PC.
- RegWrite_fpu  in  1  FPU writeback valid.
- RdW_fpu  in  6  FPU destination.
- ResultW_fpu  in  32  FPU data.
- PCW_fpu  in  PC_LEN-2  FPU PC.
- Rs1D, Rs2D  in  6  decode-stage source lookups.
- RegWriteRF  out  1  register-file write enable (registered).
- RdRF  out  6  register-file write address (registered).
- ResultRF  out  32  register-file write data (registered).
- PCRF  out  PC_LEN-2  PC of the write, for trace (registered).
- fwd_hit1, fwd_hit2  out  1  source matches a live queue entry.
- fwd_data1, fwd_data2  out  32  forwarded data.
- full  out  1  backpressure to the FPU issue logic.
- overflow  out  1  sticky error flag.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rstN low, async): RegWriteRF=0, RdRF=0, ResultRF=0, PCRF=0, queue empty, count=0, overflow=0. All entries invalidated mid-operation; pending FPU results are lost.
- A write with Rd==6'd0 is never accepted (x0 hardwired), from either source.
- Per-cycle write-port selection; the chosen write appears on the RF outputs at the next posedge (latency 1):
  - 1. Pipe valid and RdW_pipe!=0 → pipe written. A valid FPU input is pushed to the tail.
  - 2. Else if queue non-empty → pop head. A live head is written. A squashed head is discarded and the cycle produces no write (RegWriteRF=0). A valid FPU input is pushed the same cycle.
  - 3. Else if FPU valid and RdW_fpu!=0 → FPU written directly, bypassing the queue.
  - 4. Else RegWriteRF=0; RdRF, ResultRF and PCRF are driven 0.
- Squash:
  - An accepted pipe write to Rd marks every live queue entry with the same Rd as squashed in the same cycle. Pipe results are architecturally newer than queued FPU results.
  - If the FPU input has the same Rd as an accepted pipe write in the same cycle, the FPU input is dropped (not pushed).
- FIFO: wrapped head/tail pointers plus an explicit count; a simultaneous push and pop leaves count unchanged.
- full = (count >= DEPTH-1), giving the producer one cycle of slack.
- Push while count==DEPTH with no pop: input dropped, overflow set to 1 and held until reset.
- Pop on an empty queue never occurs by construction.

Optional Feature:
- WB_MERGE_FWD_EN defined:
  - fwd_hitN=1 when RsND!=0 and matches a live (unsquashed) queue entry; fwd_dataN = data of the youngest such entry (closest to tail).
  - Purely combinational on the current queue state. Entries in the RF output register are not forwarded; the register file handles write-before-read.
- Not defined: fwd_hit1/2=0 and fwd_data1/2=0; no comparators are built.

Test Plan:
- Reset, then FPU-only write Rd=6'h21, data 32'h3F800000 → next cycle RegWriteRF=1, RdRF=6'h21, ResultRF=32'h3F800000; count stays 0.
- Pipe Rd=5 data 7 together with FPU Rd=6'h22 data 9 → cycle+1 writes Rd5=7; cycle+2 writes Rd 6'h22=9; count goes 1 then 0.
- Queue FPU Rd=6'h23, then pipe write Rd=6'h23 → queued entry squashed. The pop cycle has RegWriteRF=0; final RF write to 6'h23 is the pipe value only.
- Pipe and FPU both target Rd=6'h24 in the same cycle → only the pipe write occurs; count=0.
- Continuous pipe writes with 4 FPU pushes (DEPTH=4) → full asserts at count=3. A 5th push sets overflow=1, count stays 4. Assert rstN low mid-stream → all outputs 0 immediately.
- With WB_MERGE_FWD_EN: queue Rd=6'h25 data A, then Rd=6'h25 data B; Rs1D=6'h25 → fwd_hit1=1, fwd_data1=B. With Rs2D=0 → fwd_hit2=0.
